t03_hw_timer: RTL and testbench

Parametrised free-running hardware timer, successor to the fixed divide-by-10001 clock counter. A programmable prescaler generates a timebase tick that advances a WIDTH-bit count. NUM_CMP compare channels each raise a sticky flag on match, in one-shot or periodic mode. Flags are combined into a single maskable interrupt. Sits beside the CPU as the system time and alarm source; software reads count and programs the channels through the register/bus shim.

---
 rtl/t03_timer_pkg.sv | 19 +
 rtl/t03_timer_cmp_ch.sv | 65 ++++++
 rtl/t03_hw_timer.sv | 100 ++++++++++
 tb/tb_t03_hw_timer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_timer_pkg.sv
// Shared types and default parameters for the t03 hardware timer.
// Channel FSM encoding and the cmp_sel width helper live here.
package t03_timer_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_PRE_W   = 16;
    localparam int DEF_NUM_CMP = 2;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ARMED = 1'b1
    } ch_state_t;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/t03_timer_cmp_ch.sv
// One compare channel: value/mode registers, IDLE/ARMED FSM, sticky match flag.
// Flag is set on the increment edge whose new count equals the value; no backpressure.
module t03_timer_cmp_ch
    import t03_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [WIDTH-1:0] next_count,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_periodic,
    input  logic             ack,
    output logic             flag
);

    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [WIDTH-1:0] cmp_val;
    logic             periodic;
    logic             match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (wr) begin
            state_nxt = CH_ARMED;
        end else if (match && !periodic) begin
            state_nxt = CH_IDLE;
        end
    end

    // A write in the match cycle replaces the old value, so it suppresses the match.
    always_comb begin
        match = (state == CH_ARMED) && inc && !wr && (next_count == cmp_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_val  <= '0;
            periodic <= 1'b0;
            flag     <= 1'b0;
        end else begin
            if (wr) begin
                cmp_val  <= wr_data;
                periodic <= wr_periodic;
            end
            if (match) begin
                flag <= 1'b1;
            end else if (ack) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/t03_hw_timer.sv
// Free-running prescaled timer with NUM_CMP compare channels, overflow flag and masked irq.
// Count/flags update on the tick edge, irq lags flags by one cycle; never stalls.
module t03_hw_timer
    import t03_timer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRE_W   = DEF_PRE_W,
    parameter int NUM_CMP = DEF_NUM_CMP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [PRE_W-1:0]              prescale,
    input  logic                          clear,
    input  logic                          cmp_wr,
    input  logic [sel_w(NUM_CMP)-1:0]     cmp_sel,
    input  logic [WIDTH-1:0]              cmp_data,
    input  logic                          cmp_periodic,
    input  logic [NUM_CMP:0]              irq_en,
    input  logic [NUM_CMP:0]              irq_ack,
    output logic [WIDTH-1:0]              count,
    output logic                          tick,
    output logic [NUM_CMP:0]              flags,
    output logic                          irq
);

    localparam int SEL_W = sel_w(NUM_CMP);

    logic [PRE_W-1:0]   pre_cnt;
    logic [WIDTH-1:0]   count_nxt;
    logic               inc;
    logic               ovf;
    logic [NUM_CMP-1:0] cmp_flags;

    // >= lets a divisor lowered below pre_cnt fire on the next enabled cycle.
    assign inc       = en && !clear && (pre_cnt >= prescale);
    assign count_nxt = count + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            count   <= '0;
            tick    <= 1'b0;
        end else if (clear) begin
            pre_cnt <= '0;
            count   <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            if (pre_cnt >= prescale) begin
                pre_cnt <= '0;
                count   <= count_nxt;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (inc && (&count)) begin
            ovf <= 1'b1;
        end else if (irq_ack[NUM_CMP]) begin
            ovf <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CMP; i++) begin : g_ch
        localparam logic [SEL_W-1:0] SEL = SEL_W'(i);

        t03_timer_cmp_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .inc         (inc),
            .next_count  (count_nxt),
            .wr          (cmp_wr && (cmp_sel == SEL)),
            .wr_data     (cmp_data),
            .wr_periodic (cmp_periodic),
            .ack         (irq_ack[i]),
            .flag        (cmp_flags[i])
        );
    end

    assign flags = {ovf, cmp_flags};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(flags & irq_en);
        end
    end

endmodule

// File: tb/tb_t03_hw_timer.sv
// Directed bench for t03_hw_timer at WIDTH=8, two compare channels (flags[2] = overflow).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_t03_hw_timer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] prescale;
    logic        clear;
    logic        cmp_wr;
    logic [0:0]  cmp_sel;
    logic [7:0]  cmp_data;
    logic        cmp_periodic;
    logic [2:0]  irq_en;
    logic [2:0]  irq_ack;
    logic [7:0]  count;
    logic        tick;
    logic [2:0]  flags;
    logic        irq;

    int total;
    int bad;

    t03_hw_timer #(
        .WIDTH   (8),
        .PRE_W   (16),
        .NUM_CMP (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .clear        (clear),
        .cmp_wr       (cmp_wr),
        .cmp_sel      (cmp_sel),
        .cmp_data     (cmp_data),
        .cmp_periodic (cmp_periodic),
        .irq_en       (irq_en),
        .irq_ack      (irq_ack),
        .count        (count),
        .tick         (tick),
        .flags        (flags),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        en    = 1'b0;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic write_ch(input logic sel, input logic [7:0] val, input logic per);
        cmp_wr       = 1'b1;
        cmp_sel      = sel;
        cmp_data     = val;
        cmp_periodic = per;
        cyc(1);
        cmp_wr = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (count !== 8'd0) begin bad++; $display("FAIL por_count got=%0d want=0", count); end
        total++; if ({tick, flags, irq} !== 5'b0) begin bad++; $display("FAIL por_status got=%b want=00000", {tick, flags, irq}); end
        @(posedge clk); #1;
        rst = 1'b0;
        irq_en = 3'b001;
        write_ch(1'b0, 8'd3, 1'b0);
        prescale = 16'd3;
        en = 1'b1;
        cyc(40);
        total++; if (count !== 8'd10 || tick !== 1'b1) begin bad++; $display("FAIL run10 got count=%0d tick=%b want 10/1", count, tick); end
        total++; if (flags !== 3'b001 || irq !== 1'b1) begin bad++; $display("FAIL run10_flag got flags=%b irq=%b want 001/1", flags, irq); end
        rst = 1'b1;
        #1;
        total++; if (count !== 8'd0 || flags !== 3'b000 || irq !== 1'b0 || tick !== 1'b0) begin
            bad++; $display("FAIL async_rst got count=%0d flags=%b irq=%b tick=%b want 0", count, flags, irq, tick);
        end
        cyc(1);
        rst = 1'b0;
        cyc(3);
        total++; if (count !== 8'd0 || tick !== 1'b0) begin bad++; $display("FAIL post_rst_wait got count=%0d tick=%b want 0/0", count, tick); end
        cyc(1);
        total++; if (count !== 8'd1 || tick !== 1'b1 || flags !== 3'b000) begin
            bad++; $display("FAIL post_rst_tick got count=%0d tick=%b flags=%b want 1/1/000", count, tick, flags);
        end
        do_clear();
    endtask

    task automatic test_fast();
        prescale = 16'd0;
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            total++; if (count !== 8'(i) || tick !== 1'b1) begin bad++; $display("FAIL fast_%0d got count=%0d tick=%b want %0d/1", i, count, tick, i); end
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            total++; if (count !== 8'd6 || tick !== 1'b0) begin bad++; $display("FAIL hold_%0d got count=%0d tick=%b want 6/0", i, count, tick); end
        end
        en = 1'b1;
        cyc(1);
        total++; if (count !== 8'd7) begin bad++; $display("FAIL resume got count=%0d want 7", count); end
        do_clear();
    endtask

    task automatic test_oneshot();
        prescale = 16'd1;
        irq_en = 3'b001;
        write_ch(1'b0, 8'd5, 1'b0);
        en = 1'b1;
        cyc(9);
        total++; if (count !== 8'd4 || flags !== 3'b000) begin bad++; $display("FAIL os_before got count=%0d flags=%b want 4/000", count, flags); end
        cyc(1);
        total++; if (count !== 8'd5 || flags !== 3'b001 || tick !== 1'b1 || irq !== 1'b0) begin
            bad++; $display("FAIL os_match got count=%0d flags=%b tick=%b irq=%b want 5/001/1/0", count, flags, tick, irq);
        end
        cyc(1);
        total++; if (irq !== 1'b1 || count !== 8'd5) begin bad++; $display("FAIL os_irq got irq=%b count=%0d want 1/5", irq, count); end
        irq_ack = 3'b001;
        cyc(1);
        irq_ack = 3'b000;
        total++; if (flags !== 3'b000 || count !== 8'd6 || irq !== 1'b1) begin
            bad++; $display("FAIL os_ack got flags=%b count=%0d irq=%b want 000/6/1", flags, count, irq);
        end
        cyc(1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL os_irq_drop got irq=%b want 0", irq); end
        prescale = 16'd0;
        cyc(258);
        total++; if (count !== 8'd8 || flags !== 3'b100 || irq !== 1'b0) begin
            bad++; $display("FAIL os_no_refire got count=%0d flags=%b irq=%b want 8/100/0", count, flags, irq);
        end
        irq_ack = 3'b111;
        do_clear();
        irq_ack = 3'b000;
        total++; if (flags !== 3'b000 || count !== 8'd0) begin bad++; $display("FAIL ack_all got flags=%b count=%0d want 000/0", flags, count); end
    endtask

    task automatic test_periodic();
        prescale = 16'd0;
        irq_en = 3'b110;
        write_ch(1'b1, 8'h10, 1'b1);
        en = 1'b1;
        cyc(15);
        total++; if (count !== 8'd15 || flags !== 3'b000) begin bad++; $display("FAIL per_before got count=%0d flags=%b want 15/000", count, flags); end
        cyc(1);
        total++; if (count !== 8'h10 || flags !== 3'b010) begin bad++; $display("FAIL per_match1 got count=%0d flags=%b want 16/010", count, flags); end
        irq_ack = 3'b010;
        cyc(1);
        irq_ack = 3'b000;
        total++; if (count !== 8'h11 || flags !== 3'b000 || irq !== 1'b1) begin
            bad++; $display("FAIL per_ack got count=%0d flags=%b irq=%b want 17/000/1", count, flags, irq);
        end
        cyc(238);
        total++; if (count !== 8'hFF || flags !== 3'b000 || irq !== 1'b0) begin
            bad++; $display("FAIL per_ff got count=%0d flags=%b irq=%b want 255/000/0", count, flags, irq);
        end
        cyc(1);
        total++; if (count !== 8'h00 || flags !== 3'b100) begin bad++; $display("FAIL per_wrap got count=%0d flags=%b want 0/100", count, flags); end
        cyc(1);
        total++; if (count !== 8'h01 || irq !== 1'b1) begin bad++; $display("FAIL per_ovf_irq got count=%0d irq=%b want 1/1", count, irq); end
        cyc(15);
        total++; if (count !== 8'h10 || flags !== 3'b110) begin bad++; $display("FAIL per_match2 got count=%0d flags=%b want 16/110", count, flags); end
        irq_ack = 3'b111;
        do_clear();
        irq_ack = 3'b000;
    endtask

    task automatic test_ack_collision();
        prescale = 16'd0;
        write_ch(1'b0, 8'd3, 1'b0);
        en = 1'b1;
        cyc(2);
        total++; if (count !== 8'd2 || flags !== 3'b000) begin bad++; $display("FAIL ackc_pre got count=%0d flags=%b want 2/000", count, flags); end
        irq_ack = 3'b001;
        cyc(1);
        total++; if (count !== 8'd3 || flags !== 3'b001) begin bad++; $display("FAIL ackc_set_wins got count=%0d flags=%b want 3/001", count, flags); end
        cyc(1);
        irq_ack = 3'b000;
        total++; if (count !== 8'd4 || flags !== 3'b000) begin bad++; $display("FAIL ackc_clear got count=%0d flags=%b want 4/000", count, flags); end
        do_clear();
    endtask

    task automatic test_wr_collision();
        prescale = 16'd0;
        write_ch(1'b0, 8'd3, 1'b0);
        en = 1'b1;
        cyc(2);
        write_ch(1'b0, 8'd6, 1'b0);
        total++; if (count !== 8'd3 || flags !== 3'b000) begin bad++; $display("FAIL wrc_no_flag got count=%0d flags=%b want 3/000", count, flags); end
        cyc(2);
        total++; if (count !== 8'd5 || flags !== 3'b000) begin bad++; $display("FAIL wrc_wait got count=%0d flags=%b want 5/000", count, flags); end
        cyc(1);
        total++; if (count !== 8'd6 || flags !== 3'b001) begin bad++; $display("FAIL wrc_new_val got count=%0d flags=%b want 6/001", count, flags); end
        do_clear();
    endtask

    task automatic test_prescale_change();
        prescale = 16'd100;
        en = 1'b1;
        cyc(50);
        total++; if (count !== 8'd0 || tick !== 1'b0) begin bad++; $display("FAIL psc_hold got count=%0d tick=%b want 0/0", count, tick); end
        prescale = 16'd2;
        cyc(1);
        total++; if (count !== 8'd1 || tick !== 1'b1) begin bad++; $display("FAIL psc_immediate got count=%0d tick=%b want 1/1", count, tick); end
        cyc(2);
        total++; if (count !== 8'd1 || tick !== 1'b0) begin bad++; $display("FAIL psc_gap got count=%0d tick=%b want 1/0", count, tick); end
        cyc(1);
        total++; if (count !== 8'd2 || tick !== 1'b1) begin bad++; $display("FAIL psc_period got count=%0d tick=%b want 2/1", count, tick); end
        cyc(15);
        total++; if (count !== 8'd7 || tick !== 1'b1 || flags !== 3'b001) begin
            bad++; $display("FAIL psc_seven got count=%0d tick=%b flags=%b want 7/1/001", count, tick, flags);
        end
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        total++; if (count !== 8'd0 || tick !== 1'b0 || flags !== 3'b001) begin
            bad++; $display("FAIL clr_run got count=%0d tick=%b flags=%b want 0/0/001", count, tick, flags);
        end
        cyc(2);
        total++; if (count !== 8'd0) begin bad++; $display("FAIL clr_pre got count=%0d want 0", count); end
        cyc(1);
        total++; if (count !== 8'd1 || tick !== 1'b1) begin bad++; $display("FAIL clr_first_tick got count=%0d tick=%b want 1/1", count, tick); end
        en = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        en           = 1'b0;
        prescale     = '0;
        clear        = 1'b0;
        cmp_wr       = 1'b0;
        cmp_sel      = '0;
        cmp_data     = '0;
        cmp_periodic = 1'b0;
        irq_en       = '0;
        irq_ack      = '0;
        #1;
        test_reset();
        test_fast();
        test_oneshot();
        test_periodic();
        test_ack_collision();
        test_wr_collision();
        test_prescale_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
